// File: rtl/vga_fb_pkg.sv
// Shared types and default sizes for the VGA framebuffer arbiter.
// The owner enum names who drives the RAM in a given cycle. mem_req_t bundles
// one registered RAM command: enable, write enable, address and write data.
package vga_fb_pkg;

  localparam int unsigned DataWDef       = 24;
  localparam int unsigned BufWordsDef    = 76800;
  localparam int unsigned PixAwDef       = 17;
  localparam int unsigned MemAwDef       = 18;
  localparam int unsigned StarveLimitDef = 800;
  localparam int unsigned WaitW          = 16;

  typedef enum logic [1:0] {
    OwnIdle,
    OwnDisp,
    OwnHost
  } owner_e;

  typedef struct packed {
    logic                en;
    logic                we;
    logic [MemAwDef-1:0] addr;
    logic [DataWDef-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/vga_swap_ctrl.sv
// Front/back buffer swap control.
// Ports:
//   clock, reset      - clock and synchronous active-high reset
//   swap_req_i        - one-cycle swap request pulse
//   vblank_i          - one-cycle pulse at start of vertical blank
//   swap_pending_o    - a swap is armed and waiting for vblank
//   front_sel_o       - current front buffer (0 = lower half)
//   swap_done_o       - one-cycle pulse, two cycles after the swapping vblank
module vga_swap_ctrl (
  input  logic clock,
  input  logic reset,
  input  logic swap_req_i,
  input  logic vblank_i,
  output logic swap_pending_o,
  output logic front_sel_o,
  output logic swap_done_o
);

  logic pending_d, pending_q;
  logic front_q;
  logic fire;
  logic fire_q;
  logic done_q;

  // A request arriving in the same cycle as vblank swaps immediately.
  assign fire = vblank_i & (pending_q | swap_req_i);

  always_comb begin
    pending_d = pending_q;
    if (fire) begin
      pending_d = 1'b0;
    end else if (swap_req_i) begin
      pending_d = 1'b1;  // no effect if already pending: requests do not queue
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q <= 1'b0;
      front_q   <= 1'b0;
      fire_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      front_q   <= front_q ^ fire;
      fire_q    <= fire;
      done_q    <= fire_q;
    end
  end

  assign swap_pending_o = pending_q;
  assign front_sel_o    = front_q;
  assign swap_done_o    = done_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Arbitrates one single-port synchronous framebuffer RAM between VGA scan-out
// reads (strict priority) and host pixel writes, double-buffered with swaps
// at vertical blank.
// Ports:
//   clock, reset             - clock, synchronous active-high reset
//   io_disp_*                - display read request/ack, read data/valid (latency 2)
//   io_host_*                - host write handshake, out-of-range error, starvation flag
//   io_swap_req/io_swap_done - buffer swap request and completion pulse
//   io_front_sel, io_vblank  - current front buffer, vertical blank pulse
//   io_mem_*                 - registered RAM command and RAM read data
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int unsigned DATA_W       = DataWDef,
  parameter int unsigned BUF_WORDS    = BufWordsDef,
  parameter int unsigned PIX_AW       = PixAwDef,
  parameter int unsigned MEM_AW       = MemAwDef,
  parameter int unsigned STARVE_LIMIT = StarveLimitDef
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_disp_req,
  input  logic [PIX_AW-1:0] io_disp_addr,
  output logic              io_disp_ack,
  output logic [DATA_W-1:0] io_disp_rdata,
  output logic              io_disp_rvalid,
  input  logic              io_host_valid,
  input  logic [PIX_AW-1:0] io_host_addr,
  input  logic [DATA_W-1:0] io_host_wdata,
  output logic              io_host_ready,
  output logic              io_host_err,
  output logic              io_host_starved,
  input  logic              io_swap_req,
  output logic              io_swap_done,
  output logic              io_front_sel,
  input  logic              io_vblank,
  output logic              io_mem_en,
  output logic              io_mem_we,
  output logic [MEM_AW-1:0] io_mem_addr,
  output logic [DATA_W-1:0] io_mem_wdata,
  input  logic [DATA_W-1:0] io_mem_rdata
);

  logic swap_pending;
  logic front_sel;

  vga_swap_ctrl u_swap_ctrl (
    .clock          (clock),
    .reset          (reset),
    .swap_req_i     (io_swap_req),
    .vblank_i       (io_vblank),
    .swap_pending_o (swap_pending),
    .front_sel_o    (front_sel),
    .swap_done_o    (io_swap_done)
  );

  // Grant decision; nothing is granted while reset is asserted.
  owner_e owner;
  always_comb begin
    owner = OwnIdle;
    if (!reset) begin
      if (io_disp_req) begin
        owner = OwnDisp;
      end else if (io_host_valid && !swap_pending) begin
        owner = OwnHost;
      end
    end
  end

  assign io_disp_ack   = io_disp_req & ~reset;
  assign io_host_ready = ~io_disp_req & ~swap_pending & ~reset;

  logic              disp_in_range, host_in_range;
  logic [MEM_AW-1:0] disp_maddr, host_maddr;

  assign disp_in_range = 32'(io_disp_addr) < BUF_WORDS;
  assign host_in_range = 32'(io_host_addr) < BUF_WORDS;
  // Display reads the front half, host writes the back half.
  assign disp_maddr = MEM_AW'(io_disp_addr) + (front_sel ? MEM_AW'(BUF_WORDS) : '0);
  assign host_maddr = MEM_AW'(io_host_addr) + (front_sel ? '0 : MEM_AW'(BUF_WORDS));

  mem_req_t mem_d, mem_q;
  logic     rd_pend_d, rd_pend_q;
  logic     rd_ok_d, rd_ok_q;
  logic     err_d, err_q;

  always_comb begin
    mem_d     = '0;
    rd_pend_d = 1'b0;
    rd_ok_d   = 1'b0;
    err_d     = 1'b0;
    unique case (owner)
      OwnDisp: begin
        mem_d.en   = disp_in_range;
        mem_d.addr = disp_maddr;
        rd_pend_d  = 1'b1;
        rd_ok_d    = disp_in_range;
      end
      OwnHost: begin
        mem_d.en    = host_in_range;
        mem_d.we    = host_in_range;
        mem_d.addr  = host_maddr;
        mem_d.wdata = io_host_wdata;
        err_d       = ~host_in_range;
      end
      OwnIdle: ;
    endcase
  end

  // Second read stage: rvalid always follows an ack by two cycles; data is
  // forced to zero for out-of-range reads that never touched the RAM.
  logic rvalid_q;
  logic rd_ok2_q;

  logic [WaitW-1:0] wait_d, wait_q;
  logic             starved_q;

  always_comb begin
    wait_d = '0;
    if (io_host_valid && !io_host_ready) begin
      wait_d = (wait_q == {WaitW{1'b1}}) ? wait_q : wait_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_ok_q   <= 1'b0;
      err_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      rd_ok2_q  <= 1'b0;
      wait_q    <= '0;
      starved_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      rd_pend_q <= rd_pend_d;
      rd_ok_q   <= rd_ok_d;
      err_q     <= err_d;
      rvalid_q  <= rd_pend_q;
      rd_ok2_q  <= rd_pend_q & rd_ok_q;
      wait_q    <= wait_d;
      starved_q <= 32'(wait_d) >= STARVE_LIMIT;
    end
  end

  assign io_mem_en       = mem_q.en;
  assign io_mem_we       = mem_q.we;
  assign io_mem_addr     = mem_q.addr;
  assign io_mem_wdata    = mem_q.wdata;
  assign io_disp_rvalid  = rvalid_q;
  assign io_disp_rdata   = rd_ok2_q ? io_mem_rdata : '0;
  assign io_host_err     = err_q;
  assign io_host_starved = starved_q;
  assign io_front_sel    = front_sel;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;

  localparam int unsigned BUF = 76800;

  logic        clock;
  logic        reset;
  logic        io_disp_req;
  logic [16:0] io_disp_addr;
  logic        io_disp_ack;
  logic [23:0] io_disp_rdata;
  logic        io_disp_rvalid;
  logic        io_host_valid;
  logic [16:0] io_host_addr;
  logic [23:0] io_host_wdata;
  logic        io_host_ready;
  logic        io_host_err;
  logic        io_host_starved;
  logic        io_swap_req;
  logic        io_swap_done;
  logic        io_front_sel;
  logic        io_vblank;
  logic        io_mem_en;
  logic        io_mem_we;
  logic [17:0] io_mem_addr;
  logic [23:0] io_mem_wdata;
  logic [23:0] io_mem_rdata;

  vga_fb_arbiter dut (
    .clock           (clock),
    .reset           (reset),
    .io_disp_req     (io_disp_req),
    .io_disp_addr    (io_disp_addr),
    .io_disp_ack     (io_disp_ack),
    .io_disp_rdata   (io_disp_rdata),
    .io_disp_rvalid  (io_disp_rvalid),
    .io_host_valid   (io_host_valid),
    .io_host_addr    (io_host_addr),
    .io_host_wdata   (io_host_wdata),
    .io_host_ready   (io_host_ready),
    .io_host_err     (io_host_err),
    .io_host_starved (io_host_starved),
    .io_swap_req     (io_swap_req),
    .io_swap_done    (io_swap_done),
    .io_front_sel    (io_front_sel),
    .io_vblank       (io_vblank),
    .io_mem_en       (io_mem_en),
    .io_mem_we       (io_mem_we),
    .io_mem_addr     (io_mem_addr),
    .io_mem_wdata    (io_mem_wdata),
    .io_mem_rdata    (io_mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM model: contents are a fixed function of the address; the output is
  // garbage whenever no read was issued, so ungated data shows up.
  function automatic logic [23:0] ram_f(input logic [17:0] a);
    return {6'h2D, a} ^ 24'h5A5A5A;
  endfunction

  always @(posedge clock) begin
    if (io_mem_en && !io_mem_we) io_mem_rdata <= ram_f(io_mem_addr);
    else                         io_mem_rdata <= 24'hBADBAD;
  end

  int   n_chk;
  int   n_fail;
  int   cyc;
  logic exp_front;

  typedef struct {
    int          due;
    logic [23:0] data;
  } rd_exp_t;
  rd_exp_t sbq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] exp_rd(input logic [16:0] da);
    logic [17:0] ma;
    if (32'(da) >= BUF) return 24'h0;
    ma = 18'(da) + (exp_front ? 18'(BUF) : 18'd0);
    return ram_f(ma);
  endfunction

  task automatic drive(input logic dr, input logic [16:0] da, input logic hv,
                       input logic [16:0] ha, input logic [23:0] hd,
                       input logic sr, input logic vb);
    rd_exp_t e;
    io_disp_req   = dr;
    io_disp_addr  = da;
    io_host_valid = hv;
    io_host_addr  = ha;
    io_host_wdata = hd;
    io_swap_req   = sr;
    io_vblank     = vb;
    if (dr && !reset) begin
      e.due  = cyc + 2;
      e.data = exp_rd(da);
      sbq.push_back(e);
    end
  endtask

  task automatic idle();
    drive(1'b0, 17'd0, 1'b0, 17'd0, 24'd0, 1'b0, 1'b0);
  endtask

  task automatic sb_mon();
    rd_exp_t e;
    if (io_disp_rvalid) begin
      if (sbq.size() == 0) begin
        chk("rvalid_spurious", 32'(io_disp_rvalid), 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("rd_latency", cyc, e.due);
        chk("rd_data", 32'(io_disp_rdata), 32'(e.data));
      end
    end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      chk("rd_missing", 32'(io_disp_rvalid), 32'd1);
    end
  endtask

  task automatic to_neg();
    @(negedge clock);
    sb_mon();
  endtask

  task automatic to_next();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic step();
    to_neg();
    to_next();
  endtask

  typedef struct {
    logic        dr;
    logic [16:0] da;
    logic        hv;
    logic [16:0] ha;
    logic [23:0] hd;
    logic        ack;
    logic        rdy;
    logic        en;
    logic        we;
    logic [17:0] addr;
    logic        err;
  } vec_t;

  localparam int NV = 12;
  vec_t vt[NV];

  initial begin
    vec_t p;
    n_chk     = 0;
    n_fail    = 0;
    cyc       = 0;
    exp_front = 1'b0;
    reset     = 1'b1;
    idle();

    //        dr    da         hv    ha         hd          ack   rdy   en    we    addr        err
    vt[0]  = '{1'b1, 17'd0,     1'b0, 17'd0,     24'h000000, 1'b1, 1'b0, 1'b1, 1'b0, 18'd0,      1'b0};
    vt[1]  = '{1'b1, 17'd1,     1'b0, 17'd0,     24'h000000, 1'b1, 1'b0, 1'b1, 1'b0, 18'd1,      1'b0};
    vt[2]  = '{1'b1, 17'd2,     1'b0, 17'd0,     24'h000000, 1'b1, 1'b0, 1'b1, 1'b0, 18'd2,      1'b0};
    vt[3]  = '{1'b1, 17'd3,     1'b0, 17'd0,     24'h000000, 1'b1, 1'b0, 1'b1, 1'b0, 18'd3,      1'b0};
    vt[4]  = '{1'b0, 17'd0,     1'b1, 17'd10,    24'hFF0000, 1'b0, 1'b1, 1'b1, 1'b1, 18'd76810,  1'b0};
    vt[5]  = '{1'b1, 17'd5,     1'b1, 17'd10,    24'hFF0000, 1'b1, 1'b0, 1'b1, 1'b0, 18'd5,      1'b0};
    vt[6]  = '{1'b1, 17'd76800, 1'b0, 17'd0,     24'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 18'd0,      1'b0};
    vt[7]  = '{1'b0, 17'd0,     1'b1, 17'd80000, 24'h00FF00, 1'b0, 1'b1, 1'b0, 1'b0, 18'd0,      1'b1};
    vt[8]  = '{1'b1, 17'd76799, 1'b0, 17'd0,     24'h000000, 1'b1, 1'b0, 1'b1, 1'b0, 18'd76799,  1'b0};
    vt[9]  = '{1'b0, 17'd0,     1'b0, 17'd0,     24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 18'd0,      1'b0};
    vt[10] = '{1'b0, 17'd0,     1'b1, 17'd76799, 24'h123456, 1'b0, 1'b1, 1'b1, 1'b1, 18'd153599, 1'b0};
    vt[11] = '{1'b0, 17'd0,     1'b1, 17'd76800, 24'h654321, 1'b0, 1'b1, 1'b0, 1'b0, 18'd0,      1'b1};

    // Reset state.
    to_next();
    to_next();
    to_neg();
    chk("rst_ack", 32'(io_disp_ack), 32'd0);
    chk("rst_ready", 32'(io_host_ready), 32'd0);
    chk("rst_mem_en", 32'(io_mem_en), 32'd0);
    chk("rst_mem_we", 32'(io_mem_we), 32'd0);
    chk("rst_rvalid", 32'(io_disp_rvalid), 32'd0);
    chk("rst_front", 32'(io_front_sel), 32'd0);
    chk("rst_done", 32'(io_swap_done), 32'd0);
    chk("rst_err", 32'(io_host_err), 32'd0);
    chk("rst_starved", 32'(io_host_starved), 32'd0);
    to_next();
    reset = 1'b0;

    // Table: per-cycle grant, then the registered RAM command one cycle later.
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) drive(vt[i].dr, vt[i].da, vt[i].hv, vt[i].ha, vt[i].hd, 1'b0, 1'b0);
      else        idle();
      to_neg();
      if (i < NV) begin
        chk($sformatf("v%0d_ack", i), 32'(io_disp_ack), 32'(vt[i].ack));
        chk($sformatf("v%0d_ready", i), 32'(io_host_ready), 32'(vt[i].rdy));
      end
      if (i > 0) begin
        p = vt[i-1];
        chk($sformatf("v%0d_mem_en", i-1), 32'(io_mem_en), 32'(p.en));
        chk($sformatf("v%0d_mem_we", i-1), 32'(io_mem_we), 32'(p.we));
        if (p.en) chk($sformatf("v%0d_mem_addr", i-1), 32'(io_mem_addr), 32'(p.addr));
        if (p.we) chk($sformatf("v%0d_mem_wdata", i-1), 32'(io_mem_wdata), 32'(p.hd));
        chk($sformatf("v%0d_host_err", i-1), 32'(io_host_err), 32'(p.err));
      end
      to_next();
    end
    idle(); step(); step();

    // Swap request, host stalled until vblank five cycles later.
    drive(1'b0, 17'd0, 1'b0, 17'd0, 24'd0, 1'b1, 1'b0);
    to_neg(); chk("swapreq_ready", 32'(io_host_ready), 32'd1); to_next();
    drive(1'b0, 17'd0, 1'b1, 17'd10, 24'hABCDEF, 1'b0, 1'b0);
    to_neg(); chk("pend_ready", 32'(io_host_ready), 32'd0); to_next();
    to_neg(); chk("pend_no_write", 32'(io_mem_en), 32'd0); to_next();
    step(); step();
    drive(1'b0, 17'd0, 1'b1, 17'd10, 24'hABCDEF, 1'b0, 1'b1);
    to_neg(); chk("vblank_front_old", 32'(io_front_sel), 32'd0); to_next();
    exp_front = 1'b1;
    drive(1'b0, 17'd0, 1'b1, 17'd10, 24'hABCDEF, 1'b0, 1'b0);
    to_neg();
    chk("swap_front_new", 32'(io_front_sel), 32'd1);
    chk("swap_done_early", 32'(io_swap_done), 32'd0);
    chk("swap_ready_back", 32'(io_host_ready), 32'd1);
    to_next();
    drive(1'b1, 17'd3, 1'b1, 17'd10, 24'hABCDEF, 1'b0, 1'b0);
    to_neg();
    chk("swap_done", 32'(io_swap_done), 32'd1);
    chk("swapped_wr_en", 32'(io_mem_en), 32'd1);
    chk("swapped_wr_we", 32'(io_mem_we), 32'd1);
    chk("swapped_wr_addr", 32'(io_mem_addr), 32'd10);
    chk("swapped_wr_data", 32'(io_mem_wdata), 32'hABCDEF);
    to_next();
    idle();
    to_neg();
    chk("swap_done_pulse", 32'(io_swap_done), 32'd0);
    chk("swapped_rd_addr", 32'(io_mem_addr), 32'd76803);
    to_next();
    step();

    // swap_req and vblank together swap at once.
    drive(1'b0, 17'd0, 1'b0, 17'd0, 24'd0, 1'b1, 1'b1);
    step();
    exp_front = 1'b0;
    idle();
    to_neg(); chk("same_cyc_front", 32'(io_front_sel), 32'd0); to_next();
    to_neg();
    chk("same_cyc_done", 32'(io_swap_done), 32'd1);
    chk("same_cyc_ready", 32'(io_host_ready), 32'd1);
    to_next();

    // vblank with nothing pending.
    drive(1'b0, 17'd0, 1'b0, 17'd0, 24'd0, 1'b0, 1'b1);
    step();
    idle();
    to_neg(); chk("lone_vblank_front", 32'(io_front_sel), 32'd0); to_next();
    to_neg(); chk("lone_vblank_done", 32'(io_swap_done), 32'd0); to_next();

    // A second request while pending is not queued.
    drive(1'b0, 17'd0, 1'b0, 17'd0, 24'd0, 1'b1, 1'b0); step();
    drive(1'b0, 17'd0, 1'b0, 17'd0, 24'd0, 1'b1, 1'b0); step();
    idle(); step();
    drive(1'b0, 17'd0, 1'b0, 17'd0, 24'd0, 1'b0, 1'b1); step();
    exp_front = 1'b1;
    idle();
    to_neg(); chk("dbl_req_front", 32'(io_front_sel), 32'd1); to_next();
    to_neg(); chk("dbl_req_done", 32'(io_swap_done), 32'd1); to_next();
    drive(1'b0, 17'd0, 1'b0, 17'd0, 24'd0, 1'b0, 1'b1); step();
    idle();
    to_neg();
    chk("no_queue_front", 32'(io_front_sel), 32'd1);
    chk("no_queue_ready", 32'(io_host_ready), 32'd1);
    to_next();
    to_neg(); chk("no_queue_done", 32'(io_swap_done), 32'd0); to_next();

    // Starvation: display hogs the RAM while the host waits.
    for (int i = 0; i < 800; i++) begin
      drive(1'b1, 17'(i % 16), 1'b1, 17'd20, 24'h111111, 1'b0, 1'b0);
      to_neg();
      if (i == 799) chk("starved_799", 32'(io_host_starved), 32'd0);
      to_next();
    end
    drive(1'b0, 17'd0, 1'b1, 17'd20, 24'h111111, 1'b0, 1'b0);
    to_neg();
    chk("starved_800", 32'(io_host_starved), 32'd1);
    chk("starved_ready", 32'(io_host_ready), 32'd1);
    to_next();
    idle();
    to_neg();
    chk("starved_clear", 32'(io_host_starved), 32'd0);
    chk("starved_wr_we", 32'(io_mem_we), 32'd1);
    chk("starved_wr_addr", 32'(io_mem_addr), 32'd20);
    to_next();
    step(); step();

    // Reset in the middle of a read drops it.
    drive(1'b1, 17'd7, 1'b0, 17'd0, 24'd0, 1'b0, 1'b0);
    step();
    reset = 1'b1;
    sbq.delete();
    idle();
    step();
    reset = 1'b0;
    exp_front = 1'b0;
    to_neg();
    chk("mid_rst_rvalid", 32'(io_disp_rvalid), 32'd0);
    chk("mid_rst_front", 32'(io_front_sel), 32'd0);
    to_next();
    to_neg(); chk("mid_rst_rvalid2", 32'(io_disp_rvalid), 32'd0); to_next();

    drive(1'b1, 17'd9, 1'b0, 17'd0, 24'd0, 1'b0, 1'b0); step();
    idle(); step(); step(); step();
    chk("sb_drained", sbq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
Shares one single-port synchronous framebuffer RAM between the real-time VGA scan-out requester and a host pixel writer. It double-buffers the RAM into a front half (scanned out) and a back half (written by the host). Buffer swaps happen only at vertical blank. The block sits between the pixel-address generator that feeds the VGA driver and the framebuffer RAM, in the fast_clk domain.

Parameters:
DATA_W, 24, pixel word width (8-bit R, G, B).
BUF_WORDS, 76800, words per buffer (320x240).
PIX_AW, 17, width of display/host pixel offset.
MEM_AW, 18, RAM address width (must hold 2*BUF_WORDS).
STARVE_LIMIT, 800, host wait cycles before the starved flag is raised.

Ports:
clock  in  1  fast pixel-domain clock
reset  in  1  synchronous, active-high
io_disp_req  in  1  display read request (level, one read per cycle)
io_disp_addr  in  PIX_AW  pixel offset within front buffer
io_disp_ack  out  1  display request accepted this cycle
io_disp_rdata  out  DATA_W  read pixel
io_disp_rvalid  out  1  io_disp_rdata valid
io_host_valid  in  1  host write valid
io_host_addr  in  PIX_AW  pixel offset within back buffer
io_host_wdata  in  DATA_W  write pixel
io_host_ready  out  1  host write accepted when valid&ready
io_host_err  out  1  one-cycle pulse: accepted write was out of range and dropped
io_host_starved  out  1  host wait count >= STARVE_LIMIT
io_swap_req  in  1  one-cycle pulse: request front/back swap
io_swap_done  out  1  one-cycle pulse: swap performed
io_front_sel  out  1  current front buffer (0 = lower half)
io_vblank  in  1  one-cycle pulse at start of vertical blank
io_mem_en  out  1  RAM enable
io_mem_we  out  1  RAM write enable
io_mem_addr  out  MEM_AW  RAM address
io_mem_wdata  out  DATA_W  RAM write data
io_mem_rdata  in  DATA_W  RAM read data, 1-cycle latency after en&!we

Behaviour:
- The interface uses one clock and synchronous active-high reset: ports `clock` and `reset`, both sampled on the rising edge of `clock`.
- Reset: all outputs 0; front_sel=0; swap_pending=0; wait counter=0; in-flight read dropped, so rvalid=0 on the cycle after reset.
- Per-cycle grant, owner in {IDLE, DISP, HOST}, decided combinationally:
  - DISP if disp_req.
  - Otherwise HOST if host_valid and !swap_pending.
  - Otherwise IDLE.
- Display has strict priority: disp_ack = disp_req. host_ready = !disp_req & !swap_pending.
- RAM outputs are registered. A request granted in cycle N drives mem_en/we/addr/wdata in N+1. For a display read, rdata is captured and rvalid=1 in N+2. Sustained throughput is 1 read/cycle, with fixed latency 2.
- Address mapping:
  - disp → disp_addr + (front_sel ? BUF_WORDS : 0).
  - host → host_addr + (front_sel ? 0 : BUF_WORDS).
- Display out of range (addr >= BUF_WORDS): ack still 1, mem_en=0, rvalid still 1 at N+2 with rdata=0. This keeps latency fixed.
- Host out of range: the write is accepted (ready handshake completes), mem_en=0, and host_err pulses in N+1.
- Swap:
  - swap_req sets swap_pending.
  - On vblank with pending (or with swap_req in the same cycle), front_sel toggles at the next edge, pending clears, and swap_done pulses in the following cycle.
  - swap_req while already pending is ignored (no queueing).
  - vblank without pending does nothing.
- Host writes are stalled while pending, so no write lands in the buffer about to become front.
- Wait counter:
  - Increments, saturating at 2^16-1, each cycle host_valid & !host_ready.
  - Clears on an accepted write or when host_valid=0.
  - host_starved is registered from the compare.

Decomposition:
- Package vga_fb_pkg: owner enum (IDLE, DISP, HOST); defaults for BUF_WORDS, DATA_W, widths; the mem request bundle (en, we, addr, wdata).
- Sub-module vga_swap_ctrl: owns swap_pending, front_sel and swap_done. The arbiter, address mapper, read pipeline and starve counter stay in the top.

Test Plan:
1. Reset, then disp_req=1 for addr 0..3 in consecutive cycles → mem_addr 0..3 in cycles 1..4; rvalid high cycles 2..5 with RAM data in order.
2. host_valid with addr=10, data=0xFF0000, disp_req=0 → ready=1; mem_we=1, mem_addr=76810 next cycle. Repeat with disp_req=1 → ready=0, no write issued.
3. Swap: swap_req pulse → host_ready=0; vblank 5 cycles later → front_sel=1 one cycle after vblank, swap_done pulse the cycle after; host write addr 10 now maps to mem_addr 10.
4. swap_req and vblank in the same cycle → swap occurs. vblank with no pending request → front_sel unchanged.
5. Out of range:
   - disp_addr=76800 → mem_en=0, rvalid=1, rdata=0 at +2.
   - host_addr=80000 accepted → no write, host_err pulse.
6. Starvation: disp_req held 800 cycles with host_valid=1 → host_starved=1; drop disp_req → write accepted, starved clears the next cycle. reset asserted mid-read → no rvalid afterward.
